// File: rtl/crc16_checker.sv
// ============================================================================
// Module      : crc16_checker
// Description : Receive-side CRC-16/CCITT checker that strips a trailing
//               2-byte CRC and compares it with the CRC over the payload.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module crc16_checker #(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             init,
  input  logic [7:0]       seed,
  input  logic [7:0]       s_data,
  input  logic             s_valid,
  input  logic             s_last,
  output logic             s_ready,
  output logic             done,
  output logic             crc_ok,
  output logic             err_short,
  output logic [15:0]      crc_calc,
  output logic [15:0]      crc_rx,
  output logic [LEN_W-1:0] frame_len
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FILL1 = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Byte-wise CCITT update, equal to eight MSB-first shift steps of poly 0x1021.
  function automatic logic [15:0] crc_f(input logic [15:0] c, input logic [7:0] d);
    logic [7:0] x;
    x     = c[15:8] ^ d;
    x     = x ^ (x >> 4);
    crc_f = {c[7:0], 8'h00} ^ {x[3:0], 12'h000} ^ {3'b000, x, 5'b00000} ^ {8'h00, x};
  endfunction

  logic [1:0]       state_q, state_d;
  logic [15:0]      crc_q, crc_d;
  logic [7:0]       h0_q, h0_d;
  logic [7:0]       h1_q, h1_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             crc_ok_q, crc_ok_d;
  logic             err_short_q, err_short_d;
  logic [15:0]      crc_calc_q, crc_calc_d;
  logic [15:0]      crc_rx_q, crc_rx_d;
  logic [LEN_W-1:0] frame_len_q, frame_len_d;

  logic             accept;
  logic [15:0]      crc_next;
  logic [LEN_W-1:0] len_sat;

  assign s_ready   = (state_q != ST_DONE) && !init;
  assign accept    = s_valid && s_ready;
  assign crc_next  = crc_f(crc_q, h1_q);
  assign len_sat   = (&len_q) ? len_q : len_q + LEN_W'(1);

  assign done      = (state_q == ST_DONE);
  assign crc_ok    = crc_ok_q;
  assign err_short = err_short_q;
  assign crc_calc  = crc_calc_q;
  assign crc_rx    = crc_rx_q;
  assign frame_len = frame_len_q;

  always_comb begin
    state_d     = state_q;
    crc_d       = crc_q;
    h0_d        = h0_q;
    h1_d        = h1_q;
    len_d       = len_q;
    crc_ok_d    = crc_ok_q;
    err_short_d = err_short_q;
    crc_calc_d  = crc_calc_q;
    crc_rx_d    = crc_rx_q;
    frame_len_d = frame_len_q;

    if (init) begin
      // Abort drops the partial frame; published results are left untouched.
      state_d = ST_IDLE;
      crc_d   = 16'h0000;
      h0_d    = 8'h00;
      h1_d    = 8'h00;
      len_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            if (s_last) begin
              err_short_d = 1'b1;
              crc_ok_d    = 1'b0;
              frame_len_d = '0;
              crc_calc_d  = {8'h00, seed};
              crc_rx_d    = {8'h00, s_data};
              state_d     = ST_DONE;
            end else begin
              crc_d   = {8'h00, seed};
              h0_d    = s_data;
              len_d   = '0;
              state_d = ST_FILL1;
            end
          end
        end
        ST_FILL1: begin
          if (accept) begin
            if (s_last) begin
              err_short_d = 1'b0;
              crc_ok_d    = (crc_q == {h0_q, s_data});
              frame_len_d = '0;
              crc_calc_d  = crc_q;
              crc_rx_d    = {h0_q, s_data};
              state_d     = ST_DONE;
            end else begin
              h1_d    = h0_q;
              h0_d    = s_data;
              state_d = ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (accept) begin
            if (s_last) begin
              err_short_d = 1'b0;
              crc_ok_d    = (crc_next == {h0_q, s_data});
              frame_len_d = len_sat;
              crc_calc_d  = crc_next;
              crc_rx_d    = {h0_q, s_data};
              state_d     = ST_DONE;
            end else begin
              crc_d = crc_next;
              h1_d  = h0_q;
              h0_d  = s_data;
              len_d = len_sat;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      crc_q       <= 16'h0000;
      h0_q        <= 8'h00;
      h1_q        <= 8'h00;
      len_q       <= '0;
      crc_ok_q    <= 1'b0;
      err_short_q <= 1'b0;
      crc_calc_q  <= 16'h0000;
      crc_rx_q    <= 16'h0000;
      frame_len_q <= '0;
    end else begin
      state_q     <= state_d;
      crc_q       <= crc_d;
      h0_q        <= h0_d;
      h1_q        <= h1_d;
      len_q       <= len_d;
      crc_ok_q    <= crc_ok_d;
      err_short_q <= err_short_d;
      crc_calc_q  <= crc_calc_d;
      crc_rx_q    <= crc_rx_d;
      frame_len_q <= frame_len_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_crc16_checker.sv
// ============================================================================
// Module      : tb_crc16_checker
// Description : Self-checking bench for crc16_checker using a bit-serial CRC model.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_crc16_checker;

  logic        clk = 1'b0;
  logic        rst, init, s_valid, s_last;
  logic [7:0]  seed, s_data;
  logic        s_ready, done, crc_ok, err_short;
  logic [15:0] crc_calc, crc_rx;
  logic [15:0] frame_len;

  crc16_checker #(.LEN_W(16)) dut (
    .clk(clk), .rst(rst), .init(init), .seed(seed),
    .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
    .done(done), .crc_ok(crc_ok), .err_short(err_short),
    .crc_calc(crc_calc), .crc_rx(crc_rx), .frame_len(frame_len)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [7:0]  fb[$];
  logic [7:0]  cur_seed;

  // Results captured at every done pulse, consumed in order by expect_result.
  logic [15:0] m_calc[$], m_rx[$], m_len[$];
  logic        m_ok[$], m_short[$], m_rdy[$];
  int          done_cnt    = 0;
  int          acc_in_done = 0;

  logic [15:0] l_calc, l_rx, l_len;
  logic        l_ok, l_short;

  always @(negedge clk) begin
    if (done) begin
      m_calc.push_back(crc_calc);
      m_rx.push_back(crc_rx);
      m_len.push_back(frame_len);
      m_ok.push_back(crc_ok);
      m_short.push_back(err_short);
      m_rdy.push_back(s_ready);
      done_cnt++;
      if (s_valid && s_ready) acc_in_done++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference CRC: plain polynomial long division, one bit at a time.
  function automatic logic [15:0] ref_crc(input logic [7:0] sd, input int n);
    logic [15:0] c;
    c = {8'h00, sd};
    for (int i = 0; i < n; i++) begin
      c = c ^ {fb[i], 8'h00};
      for (int j = 0; j < 8; j++)
        c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
    end
    return c;
  endfunction

  // Called at a negedge; returns at the negedge following the accepting edge.
  task automatic send_byte(input logic [7:0] b, input logic last, input int gap_pct);
    int k;
    while ($urandom_range(99) < gap_pct) begin
      s_valid = 1'b0;
      @(negedge clk);
    end
    s_valid = 1'b1;
    s_data  = b;
    s_last  = last;
    k = 0;
    #1;
    while (!s_ready && k < 50) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (!s_ready) chk("s_ready_timeout", s_ready, 1);
    @(posedge clk);
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic send_frame(input int gap_pct);
    seed = cur_seed;
    for (int i = 0; i < fb.size(); i++)
      send_byte(fb[i], (i == fb.size() - 1), gap_pct);
    chk("done_latency", done, 1);
  endtask

  task automatic expect_result(input string tag);
    int n, k;
    logic [15:0] e_calc, e_rx, e_len;
    logic        e_ok, e_short;
    n = fb.size();
    if (n < 2) begin
      e_short = 1'b1;
      e_calc  = {8'h00, cur_seed};
      e_rx    = {8'h00, fb[0]};
      e_len   = 16'd0;
      e_ok    = 1'b0;
    end else begin
      e_short = 1'b0;
      e_calc  = ref_crc(cur_seed, n - 2);
      e_rx    = {fb[n-2], fb[n-1]};
      e_len   = 16'(n - 2);
      e_ok    = (e_calc == e_rx);
    end
    k = 0;
    while (m_ok.size() == 0 && k < 20) begin
      @(negedge clk);
      #2;
      k++;
    end
    if (m_ok.size() == 0) begin
      chk({tag, "_done_seen"}, m_ok.size(), 1);
      return;
    end
    l_calc  = m_calc.pop_front();
    l_rx    = m_rx.pop_front();
    l_len   = m_len.pop_front();
    l_ok    = m_ok.pop_front();
    l_short = m_short.pop_front();
    chk({tag, "_crc_calc"},  l_calc,  e_calc);
    chk({tag, "_crc_rx"},    l_rx,    e_rx);
    chk({tag, "_frame_len"}, l_len,   e_len);
    chk({tag, "_crc_ok"},    l_ok,    e_ok);
    chk({tag, "_err_short"}, l_short, e_short);
    chk({tag, "_ready_low"}, m_rdy.pop_front(), 0);
  endtask

  task automatic load_test1();
    fb = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'h31, 8'hC3};
    cur_seed = 8'h00;
  endtask

  initial begin
    int d0, n;
    rst = 1'b1; init = 1'b0; s_valid = 1'b0; s_last = 1'b0; seed = 8'h00; s_data = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_done",      done,      0);
    chk("rst_crc_ok",    crc_ok,    0);
    chk("rst_err_short", err_short, 0);
    chk("rst_crc_calc",  crc_calc,  0);
    chk("rst_crc_rx",    crc_rx,    0);
    chk("rst_frame_len", frame_len, 0);
    chk("rst_s_ready",   s_ready,   1);
    @(negedge clk);

    load_test1();
    send_frame(0);
    expect_result("t1");
    chk("t1_spec_calc", l_calc, 16'h31C3);
    chk("t1_spec_len",  l_len,  16'd9);

    fb[10] = 8'hC2;
    send_frame(0);
    expect_result("t2_bad");
    chk("t2_spec_ok", l_ok, 0);

    fb = {8'h41, 8'h58, 8'hE5}; cur_seed = 8'h00;
    send_frame(0);
    expect_result("t2_one");
    chk("t2_spec_calc", l_calc, 16'h58E5);

    fb = {8'h00, 8'h00}; cur_seed = 8'h00;
    send_frame(0);
    expect_result("two_zero");
    fb = {8'h00, 8'h5A}; cur_seed = 8'h5A;
    send_frame(0);
    expect_result("two_seed_ok");
    chk("two_seed_spec_ok", l_ok, 1);
    fb = {8'h00, 8'h00}; cur_seed = 8'h5A;
    send_frame(0);
    expect_result("two_seed_bad");

    fb = {8'h7E}; cur_seed = 8'h00;
    send_frame(0);
    expect_result("short");
    chk("short_spec_rx", l_rx, 16'h007E);

    // Abort with init mid-frame, with a byte offered during the init cycle.
    load_test1();
    seed = cur_seed;
    for (int i = 0; i < 4; i++) send_byte(fb[i], 1'b0, 0);
    d0 = done_cnt;
    init = 1'b1; s_valid = 1'b1; s_data = 8'hAA; s_last = 1'b0;
    #1;
    chk("init_s_ready", s_ready, 0);
    @(negedge clk);
    init = 1'b0; s_valid = 1'b0;
    send_frame(0);
    expect_result("init_abort");
    chk("init_one_done", done_cnt - d0, 1);

    // Abort with rst mid-frame.
    for (int i = 0; i < 4; i++) send_byte(fb[i], 1'b0, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_mid_calc",  crc_calc,  0);
    chk("rst_mid_ok",    crc_ok,    0);
    chk("rst_mid_len",   frame_len, 0);
    chk("rst_mid_ready", s_ready,   1);
    @(negedge clk);
    send_frame(0);
    expect_result("rst_abort");

    // Back-to-back with random valid gaps.
    d0 = done_cnt;
    send_frame(30);
    send_frame(30);
    expect_result("b2b_a");
    expect_result("b2b_b");
    chk("b2b_two_done", done_cnt - d0, 2);
    chk("acc_in_done",  acc_in_done, 0);

    // Random frames against the reference model.
    for (int f = 0; f < 8; f++) begin
      n = $urandom_range(12, 1);
      fb = {};
      for (int i = 0; i < n; i++) fb.push_back(8'($urandom_range(255)));
      cur_seed = 8'($urandom_range(255));
      if (f % 2 == 1 && n >= 2) begin
        {fb[n-2], fb[n-1]} = ref_crc(cur_seed, n - 2);
      end
      send_frame(20);
      expect_result($sformatf("rand%0d", f));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/crc16_checker.md
Name: crc16_checker

Overview:
- Receive-side companion to the byte-wise CRC-16 generator: CRC-16/CCITT (poly 0x1021), MSB-first, non-reflected, no final XOR, 8-bit seed zero-extended to 16 bits.
- Consumes a byte stream whose frames end with the 2-byte CRC, high byte first.
- Strips the trailing CRC bytes and computes the CRC over the payload only.
- Reports match/mismatch, the computed and received CRCs, and the payload length once per frame.

Parameters:
- LEN_W, 16, width of the payload byte counter `frame_len` (saturating).

Ports:
- clk  input  1  clock
- rst  input  1  reset; synchronous, active-high
- init  input  1  synchronous abort: discard the partial frame, return to IDLE
- seed  input  8  CRC seed, zero-extended to {8'h00,seed}; sampled on the first accepted byte of a frame
- s_data  input  8  stream byte
- s_valid  input  1  s_data is valid
- s_last  input  1  byte is the final byte of the frame (the CRC low byte)
- s_ready  output  1  checker can accept; a byte transfers when s_valid && s_ready
- done  output  1  one-cycle pulse: result outputs updated
- crc_ok  output  1  crc_calc == crc_rx, and the frame was not short
- err_short  output  1  frame had fewer than 2 bytes
- crc_calc  output  16  CRC computed over the payload bytes
- crc_rx  output  16  received CRC {first trailing byte, last byte}
- frame_len  output  LEN_W  payload byte count (frame bytes minus 2)

Behaviour:
- Reset:
  - State = IDLE.
  - done, crc_ok, err_short = 0.
  - crc_calc, crc_rx, frame_len = 0.
  - Internal CRC register and hold bytes = 0.
  - s_ready = 1 from the first cycle after reset, unless init is high.
- s_ready:
  - Equals 1 in IDLE, FILL1 and RUN; 0 in DONE.
  - Forced to 0 while init = 1, so no byte is ever accepted in an init cycle.
- Two-byte hold pipeline:
  - h1 is the older held byte, h0 the newer.
  - A payload byte is fed into the CRC only once two newer bytes exist behind it.
  - The last two bytes of a frame are therefore never fed; they form crc_rx.
- FSM transitions on an accepted byte b (results are registered and visible while done = 1):
  - IDLE, s_last = 0: crc <= {8'h00,seed}; h0 <= b; len <= 0; go to FILL1.
  - IDLE, s_last = 1 (1-byte frame): err_short = 1, crc_ok = 0, frame_len = 0, crc_calc = {8'h00,seed}, crc_rx = {8'h00,b}; go to DONE.
  - FILL1, s_last = 0: h1 <= h0; h0 <= b; go to RUN.
  - FILL1, s_last = 1 (empty payload): crc_calc = {8'h00,seed}, crc_rx = {h0,b}, frame_len = 0, err_short = 0, crc_ok = (crc_calc == crc_rx); go to DONE.
  - RUN, s_last = 0: crc <= F(crc,h1); h1 <= h0; h0 <= b; len <= len+1 (saturating at all-ones); stay in RUN.
  - RUN, s_last = 1: crc_calc = F(crc,h1), crc_rx = {h0,b}, frame_len = len+1 (saturating), err_short = 0, crc_ok = compare; go to DONE.
  - DONE: done = 1 for exactly this cycle, s_ready = 0; unconditionally go to IDLE next cycle.
- Latency: done is asserted the cycle after the last byte is accepted. Minimum frame-to-frame spacing is one bubble cycle.
- CRC update F(c,d):
  - x = c[15:8] ^ d
  - x = x ^ (x >> 4)
  - F = (c << 8) ^ (x << 12) ^ (x << 5) ^ x, truncated to 16 bits
  - Must be bit-identical to the generator's update.
- Idle cycles (s_valid = 0) in any state: no change.
- Result outputs hold their value between done pulses. init does not change them.
- init (not in reset):
  - Any state goes to IDLE; hold bytes and the internal CRC are discarded.
  - No done pulse is generated.
  - init during DONE: done still pulses that cycle; next state is IDLE.
- rst mid-frame: full reset; the partial frame is lost and no done pulse is generated.
- rst and init asserted together: rst dominates.

Test Plan:
- seed=0x00, bytes "123456789" (0x31..0x39), then 0x31, 0xC3 (last) -> one cycle later done=1, crc_ok=1, crc_calc=0x31C3, crc_rx=0x31C3, frame_len=9, err_short=0; s_ready=0 only in the done cycle.
- Same frame with last byte 0xC2 -> crc_ok=0, crc_calc=0x31C3, crc_rx=0x31C2; then seed=0x00, payload 0x41, trailer 0x58,0xE5 -> crc_ok=1, crc_calc=0x58E5, frame_len=1.
- Two-byte frames:
  - seed=0x00, frame 0x00,0x00 -> crc_ok=1, crc_calc=0x0000, frame_len=0.
  - seed=0x5A, frame 0x00,0x5A -> crc_ok=1, crc_calc=0x005A.
  - seed=0x5A, frame 0x00,0x00 -> crc_ok=0.
- One-byte frame 0x7E with s_last -> done, err_short=1, crc_ok=0, frame_len=0, crc_rx=0x007E.
- Abort and reset mid-frame:
  - Send 4 bytes, pulse init (s_valid held high that cycle -> not accepted), then send test 1's frame -> exactly one done, identical results to test 1.
  - Repeat the abort with rst instead -> outputs cleared, then correct result.
- Test 1's frame with random s_valid gaps, sent back-to-back twice -> two done pulses, both crc_ok=1, frame_len=9; no byte accepted during either done cycle.
